// File: rtl/fm_reset_sequencer.sv
// Sequenced reset release for a chain of downstream blocks.
// All stages are held in reset for a fixed time, then released one at a time,
// each waiting for the previous stage to report ready. A stage that never
// reports ready within the timeout parks the sequencer in ERROR.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_HOLD  | all stages in reset, counting the initial hold time
// ST_WAIT  | stages 0..idx released, waiting for stage_ready[idx]
// ST_DONE  | all stages released, ready inputs ignored
// ST_ERROR | stage timeout_stage and above back in reset, waiting for restart
module fm_reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clock_fm,
  input  logic                          reset_fm,
  input  logic                          soft_reset_req,
  input  logic [NUM_STAGES-1:0]         stage_ready,
  output logic [NUM_STAGES-1:0]         stage_reset,
  output logic                          seq_busy,
  output logic                          seq_done,
  output logic                          timeout_err,
  output logic [$clog2(NUM_STAGES)-1:0] timeout_stage
);

  localparam int IDX_W  = $clog2(NUM_STAGES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [NUM_STAGES-1:0]   stage_reset_q, stage_reset_d;
  logic                    seq_busy_q, seq_busy_d;
  logic                    seq_done_q, seq_done_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]        timeout_stage_q, timeout_stage_d;

  // State register; outputs are registered from the next-state decode so they
  // always line up with the state they describe.
  always_ff @(posedge clock_fm) begin
    if (reset_fm) begin
      state_q         <= ST_HOLD;
      idx_q           <= '0;
      hold_cnt_q      <= '0;
      wait_cnt_q      <= '0;
      stage_reset_q   <= '1;
      seq_busy_q      <= 1'b1;
      seq_done_q      <= 1'b0;
      timeout_err_q   <= 1'b0;
      timeout_stage_q <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      hold_cnt_q      <= hold_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      stage_reset_q   <= stage_reset_d;
      seq_busy_q      <= seq_busy_d;
      seq_done_q      <= seq_done_d;
      timeout_err_q   <= timeout_err_d;
      timeout_stage_q <= timeout_stage_d;
    end
  end

  // Next-state, stage index, counters and sticky error capture.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    hold_cnt_d      = hold_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    timeout_err_d   = timeout_err_q;
    timeout_stage_d = timeout_stage_q;
    if (soft_reset_req) begin
      // Restart keeps the error record so software can still see what failed.
      state_d    = ST_HOLD;
      idx_d      = '0;
      hold_cnt_d = '0;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_WAIT;
            idx_d      = '0;
            hold_cnt_d = '0;
            wait_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_WAIT: begin
          // Ready is checked first so it beats a timeout in the same cycle.
          if (stage_ready[idx_q]) begin
            wait_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d         = ST_ERROR;
            wait_cnt_d      = '0;
            timeout_err_d   = 1'b1;
            timeout_stage_d = idx_q;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the next state, captured by the state register.
  always_comb begin
    stage_reset_d = '1;
    seq_busy_d    = 1'b0;
    seq_done_d    = 1'b0;
    case (state_d)
      ST_HOLD: begin
        seq_busy_d    = 1'b1;
        stage_reset_d = '1;
      end
      ST_WAIT: begin
        seq_busy_d = 1'b1;
        for (int j = 0; j < NUM_STAGES; j++) begin
          stage_reset_d[j] = (IDX_W'(j) > idx_d);
        end
      end
      ST_DONE: begin
        seq_done_d    = 1'b1;
        stage_reset_d = '0;
      end
      ST_ERROR: begin
        for (int j = 0; j < NUM_STAGES; j++) begin
          stage_reset_d[j] = (IDX_W'(j) >= timeout_stage_d);
        end
      end
      default: ;
    endcase
  end

  assign stage_reset   = stage_reset_q;
  assign seq_busy      = seq_busy_q;
  assign seq_done      = seq_done_q;
  assign timeout_err   = timeout_err_q;
  assign timeout_stage = timeout_stage_q;

endmodule

// File: tb/tb_fm_reset_sequencer.sv
// Bench for fm_reset_sequencer: directed sequences plus randomized traffic,
// every cycle compared against a timestamp-based reference model.
module tb_fm_reset_sequencer;

  localparam int N   = 4;
  localparam int H   = 16;
  localparam int TO  = 1024;
  localparam int ALL = (1 << N) - 1;

  localparam int P_HOLD = 0;
  localparam int P_WAIT = 1;
  localparam int P_DONE = 2;
  localparam int P_ERR  = 3;

  logic         clock_fm = 1'b0;
  logic         reset_fm = 1'b1;
  logic         soft_reset_req = 1'b0;
  logic [N-1:0] stage_ready = '0;
  logic [N-1:0] stage_reset;
  logic         seq_busy;
  logic         seq_done;
  logic         timeout_err;
  logic [1:0]   timeout_stage;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: phase, active stage and the edge number the phase began
  int m_cyc    = 0;
  int m_phase  = P_HOLD;
  int m_idx    = 0;
  int m_start  = 0;
  bit m_err    = 1'b0;
  int m_tstage = 0;

  fm_reset_sequencer #(
    .NUM_STAGES(N),
    .HOLD_CYCLES(H),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_fm(clock_fm),
    .reset_fm(reset_fm),
    .soft_reset_req(soft_reset_req),
    .stage_ready(stage_ready),
    .stage_reset(stage_reset),
    .seq_busy(seq_busy),
    .seq_done(seq_done),
    .timeout_err(timeout_err),
    .timeout_stage(timeout_stage)
  );

  always #5 clock_fm = ~clock_fm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Applies the inputs seen at one rising edge to the model.
  task automatic model_step();
    m_cyc++;
    if (reset_fm) begin
      m_phase = P_HOLD; m_idx = 0; m_start = m_cyc; m_err = 1'b0; m_tstage = 0;
    end else if (soft_reset_req) begin
      m_phase = P_HOLD; m_idx = 0; m_start = m_cyc;
    end else if (m_phase == P_HOLD) begin
      if (m_cyc - m_start == H) begin
        m_phase = P_WAIT; m_idx = 0; m_start = m_cyc;
      end
    end else if (m_phase == P_WAIT) begin
      if (stage_ready[m_idx]) begin
        if (m_idx == N - 1) m_phase = P_DONE;
        else begin
          m_idx++; m_start = m_cyc;
        end
      end else if (m_cyc - m_start == TO) begin
        m_phase = P_ERR; m_err = 1'b1; m_tstage = m_idx;
      end
    end
  endtask

  function automatic logic [31:0] model_vec();
    int sr;
    int busy;
    int done;
    case (m_phase)
      P_HOLD:  sr = ALL;
      P_WAIT:  sr = ALL & ~((1 << (m_idx + 1)) - 1);
      P_DONE:  sr = 0;
      default: sr = ALL & ~((1 << m_tstage) - 1);
    endcase
    busy = (m_phase == P_HOLD || m_phase == P_WAIT) ? 1 : 0;
    done = (m_phase == P_DONE) ? 1 : 0;
    return 32'((sr << 5) | (busy << 4) | (done << 3) | (int'(m_err) << 2) | m_tstage);
  endfunction

  task automatic tick();
    @(posedge clock_fm);
    model_step();
    #1;
    chk("cycle", {23'b0, stage_reset, seq_busy, seq_done, timeout_err, timeout_stage},
        model_vec());
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_sr(input string tag, input logic [N-1:0] exp);
    chk(tag, {28'b0, stage_reset}, {28'b0, exp});
  endtask

  initial begin
    // reset state
    stage_ready = 4'b1111;
    tick();
    chk_sr("rst_sr", 4'b1111);
    chk("rst_busy", {31'b0, seq_busy}, 32'd1);
    chk("rst_done", {31'b0, seq_done}, 32'd0);
    chk("rst_err", {31'b0, timeout_err}, 32'd0);
    chk("rst_tstage", {30'b0, timeout_stage}, 32'd0);
    reset_fm = 1'b0;

    // default release timing with all stages ready
    ticks(15); chk_sr("seq_e15", 4'b1111);
    tick();    chk_sr("seq_e16", 4'b1110);
    tick();    chk_sr("seq_e17", 4'b1100);
    tick();    chk_sr("seq_e18", 4'b1000);
    tick();    chk_sr("seq_e19", 4'b0000);
    chk("seq_e19_done", {31'b0, seq_done}, 32'd0);
    tick();
    chk("seq_e20_done", {31'b0, seq_done}, 32'd1);
    chk("seq_e20_busy", {31'b0, seq_busy}, 32'd0);
    stage_ready = 4'b0000;
    ticks(5);
    chk("done_ignores_ready", {31'b0, seq_done}, 32'd1);

    // stage 1 never ready: timeout into ERROR
    stage_ready = 4'b1101;
    soft_reset_req = 1'b1; tick(); soft_reset_req = 1'b0;
    ticks(17); chk_sr("to_idx1", 4'b1100);
    ticks(1023); chk_sr("to_pre", 4'b1100);
    chk("to_pre_err", {31'b0, timeout_err}, 32'd0);
    tick();
    chk_sr("to_sr", 4'b1110);
    chk("to_err", {31'b0, timeout_err}, 32'd1);
    chk("to_tstage", {30'b0, timeout_stage}, 32'd1);
    chk("to_busy", {31'b0, seq_busy}, 32'd0);
    chk("to_done", {31'b0, seq_done}, 32'd0);
    ticks(10); chk_sr("err_held", 4'b1110);

    // restart from ERROR keeps the sticky flag
    stage_ready = 4'b1111;
    soft_reset_req = 1'b1; tick(); soft_reset_req = 1'b0;
    chk_sr("soft_sr", 4'b1111);
    chk("soft_err_kept", {31'b0, timeout_err}, 32'd1);
    ticks(16); chk_sr("soft_e16", 4'b1110);
    ticks(4);
    chk("soft_done", {31'b0, seq_done}, 32'd1);
    chk("soft_tstage_kept", {30'b0, timeout_stage}, 32'd1);

    // late ready on stage 2
    stage_ready = 4'b1011;
    soft_reset_req = 1'b1; tick(); soft_reset_req = 1'b0;
    ticks(18); chk_sr("late_idx2", 4'b1000);
    ticks(50); chk_sr("late_wait", 4'b1000);
    stage_ready = 4'b1111;
    tick(); chk_sr("late_rel3", 4'b0000);
    tick(); chk("late_done", {31'b0, seq_done}, 32'd1);

    // hard reset mid-sequence clears the sticky flag
    soft_reset_req = 1'b1; tick(); soft_reset_req = 1'b0;
    ticks(18); chk_sr("mid_idx2", 4'b1000);
    reset_fm = 1'b1; tick(); reset_fm = 1'b0;
    chk_sr("mid_rst_sr", 4'b1111);
    chk("mid_rst_err", {31'b0, timeout_err}, 32'd0);

    // ready arriving on the timeout cycle wins
    stage_ready = 4'b1101;
    ticks(17); chk_sr("race_idx1", 4'b1100);
    ticks(1023);
    stage_ready = 4'b1111;
    tick();
    chk_sr("race_sr", 4'b1000);
    chk("race_err", {31'b0, timeout_err}, 32'd0);
    chk("race_busy", {31'b0, seq_busy}, 32'd1);

    // randomized traffic
    for (int seg = 0; seg < 14; seg++) begin
      int mode;
      int stuck;
      int len;
      mode  = $urandom_range(0, 2);
      stuck = $urandom_range(0, N - 1);
      len   = $urandom_range(100, 2200);
      for (int c = 0; c < len; c++) begin
        logic [N-1:0] r;
        r = N'($urandom);
        if (mode == 1) r = r | N'($urandom);
        if (mode == 0) r[stuck] = 1'b0;
        stage_ready    = r;
        soft_reset_req = ($urandom_range(0, 399) == 0);
        reset_fm       = ($urandom_range(0, 1999) == 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
